c2c_bus_shim: RTL
=================

Name: c2c_bus_shim

Overview:
- Parametrised, registered request/response slice between one core bus master port (instruction or data) and an external slave.
- Replaces the fixed output-flop shim with a transaction-tracking FSM:
  - holds the downstream request stable until acknowledged;
  - registers the response back to the core;
  - optional timeout returning an error response;
  - transaction and timeout counters.
- One instance is used per core bus.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT, 0, cycles to wait for s_ack before forcing an error response; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, value returned on m_data_r for a timed-out read.
- COUNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- m_re  in  1  master read request; held until m_ack.
- m_we  in  1  master write request; held until m_ack.
- m_sel  in  XLEN/8  byte lanes.
- m_addr  in  XLEN  address.
- m_data_w  in  XLEN  write data.
- m_ack  out  1  one-cycle response strobe to master.
- m_data_r  out  XLEN  read data, valid with m_ack.
- m_err  out  1  timeout error, valid with m_ack.
- s_re  out  1  downstream read request.
- s_we  out  1  downstream write request.
- s_sel  out  XLEN/8  downstream byte lanes.
- s_addr  out  XLEN  downstream address.
- s_data_w  out  XLEN  downstream write data.
- s_ack  in  1  slave acknowledge.
- s_data_r  in  XLEN  slave read data, valid with s_ack.
- busy  out  1  high when FSM is not IDLE.
- txn_count  out  COUNT_W  completed transactions, saturating.
- timeout_count  out  COUNT_W  timed-out transactions, saturating.

Behaviour:
- Reset:
  - FSM returns to IDLE.
  - All outputs are 0, including counters, m_data_r and all s_* signals.
  - The wait counter is cleared.
  - Reset mid-transaction abandons it: s_re/s_we drop the cycle after reset is sampled, and no m_ack is issued.
- All outputs come from registers; there is no combinational path from any input to any output.
- IDLE:
  - s_re = s_we = 0.
  - If m_re|m_we is sampled, capture sel/addr/data_w and the request type, then go to ISSUE.
  - m_we && m_re together: the write wins; s_re stays 0.
- ISSUE:
  - s_* are driven from the captured registers and held constant regardless of m_* changes.
  - Wait counter increments each cycle.
  - If s_ack:
    - capture s_data_r (reads) or 0 (writes) into m_data_r;
    - m_err <= 0; go to RESP.
  - Else if TIMEOUT != 0 and wait counter == TIMEOUT-1:
    - m_data_r <= ERR_DATA (reads) or 0 (writes);
    - m_err <= 1; go to RESP.
  - s_re/s_we deassert on the transition to RESP.
- RESP:
  - m_ack = 1 for exactly one cycle; m_data_r and m_err are valid.
  - Go to IDLE.
  - m_* inputs are ignored this cycle. The master samples m_ack at the closing edge and presents its next request, or deasserts, from the following cycle.
- Latency:
  - Request sampled in cycle 0 → s_re/s_we high in cycle 1.
  - s_ack in cycle k → m_ack in cycle k+1.
  - Minimum round trip is m_ack in cycle 2.
  - Back-to-back: a new request is sampled in the IDLE cycle after RESP, so issue rate is at most one transaction per 3 cycles.
- s_ack outside ISSUE (late ack after a timeout, spurious ack) is ignored and changes no state.
- m_data_r and m_err hold their last value outside RESP.
- txn_count increments on every ISSUE→RESP transition, including timeouts.
- timeout_count increments on timeout transitions only.
- Both counters saturate at all-ones with no wrap.

Test Plan:
- Read, slave acks in first ISSUE cycle with s_data_r=32'h1234_5678 → s_re high cycle 1 only; m_ack cycle 2 with m_data_r=32'h1234_5678, m_err=0; txn_count=1.
- Write addr=32'h100, sel=4'b0011, data=32'hA5A5_A5A5, slave acks after 4 ISSUE cycles → s_* stable for 4 cycles; single m_ack, m_data_r=0, s_re never high.
- TIMEOUT=8, read, slave never acks → s_re high exactly 8 cycles; m_ack with m_err=1, m_data_r=32'hDEAD_BEEF; timeout_count=1; a late s_ack afterwards leaves all outputs unchanged.
- m_re and m_we both high → s_we=1, s_re=0; completes as a write.
- Reset asserted in the 2nd ISSUE cycle → next cycle s_re=0, busy=0, counters=0, no m_ack; a request after reset completes normally.
- COUNT_W=2, 5 back-to-back reads with immediate ack → txn_count saturates at 3; each m_ack is exactly 3 cycles apart.

Source files
------------

// File: rtl/c2c_bus_shim.sv
// Registered request/response slice between a core bus master and a slave.
// Tracks one transaction at a time, with optional timeout and statistics.
module c2c_bus_shim #(
    parameter int                XLEN     = 32,
    parameter int                TIMEOUT  = 0,
    parameter logic [XLEN-1:0]   ERR_DATA = XLEN'(32'hDEAD_BEEF),
    parameter int                COUNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_re,
    input  logic                 m_we,
    input  logic [XLEN/8-1:0]    m_sel,
    input  logic [XLEN-1:0]      m_addr,
    input  logic [XLEN-1:0]      m_data_w,
    output logic                 m_ack,
    output logic [XLEN-1:0]      m_data_r,
    output logic                 m_err,
    output logic                 s_re,
    output logic                 s_we,
    output logic [XLEN/8-1:0]    s_sel,
    output logic [XLEN-1:0]      s_addr,
    output logic [XLEN-1:0]      s_data_w,
    input  logic                 s_ack,
    input  logic [XLEN-1:0]      s_data_r,
    output logic                 busy,
    output logic [COUNT_W-1:0]   txn_count,
    output logic [COUNT_W-1:0]   timeout_count
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                s_re_q, s_re_d;
    logic                s_we_q, s_we_d;
    logic [XLEN/8-1:0]   sel_q, sel_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                ack_q, ack_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [COUNT_W-1:0]  txn_q, txn_d;
    logic [COUNT_W-1:0]  to_q, to_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            s_re_q  <= 1'b0;
            s_we_q  <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            txn_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            s_re_q  <= s_re_d;
            s_we_q  <= s_we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_re_d  = s_re_q;
        s_we_d  = s_we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        txn_d   = txn_q;
        to_d    = to_q;

        unique case (state_q)
            IDLE: begin
                if (m_re | m_we) begin
                    // write wins when both strobes are raised
                    s_we_d  = m_we;
                    s_re_d  = m_re & ~m_we;
                    sel_d   = m_sel;
                    addr_d  = m_addr;
                    wdata_d = m_data_w;
                    wait_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wait_d = wait_q + WAIT_W'(1);
                if (s_ack) begin
                    rdata_d = s_re_q ? s_data_r : '0;
                    err_d   = 1'b0;
                end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
                    rdata_d = s_re_q ? ERR_DATA : '0;
                    err_d   = 1'b1;
                    if (to_q != '1) to_d = to_q + COUNT_W'(1);
                end
                if (s_ack || (TIMEOUT != 0 && wait_q == WAIT_LAST)) begin
                    s_re_d  = 1'b0;
                    s_we_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                    if (txn_q != '1) txn_d = txn_q + COUNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign m_ack         = ack_q;
    assign m_data_r      = rdata_q;
    assign m_err         = err_q;
    assign s_re          = s_re_q;
    assign s_we          = s_we_q;
    assign s_sel         = sel_q;
    assign s_addr        = addr_q;
    assign s_data_w      = wdata_q;
    assign busy          = busy_q;
    assign txn_count     = txn_q;
    assign timeout_count = to_q;

endmodule
